// File: rtl/conv_window_ctrl.sv
// Raster-to-window sequencer for the 5x5 Gaussian convolution: line buffers,
// window shift register, latency tracking of result coordinates and frame control.
module conv_window_ctrl #(
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned CONV_LAT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic [7:0]   in_pixel,
    output logic [199:0] window_data,
    output logic         conv_en,
    output logic         out_valid,
    output logic [9:0]   out_x,
    output logic [8:0]   out_y,
    output logic         frame_done,
    output logic         sof_err
);

    localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned DW = $clog2(CONV_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [9:0]     x_cnt, pos_x, x_nxt;
    logic [8:0]     y_cnt, pos_y, y_nxt;
    logic           accept, sof_restart, last_pix, win_ok;
    logic [DW-1:0]  drain_cnt;

    // Each word holds one column of rows y-4..y-1, oldest row in the low byte.
    logic [31:0]    lb_mem [IMG_W];
    logic [31:0]    lb_rd;
    logic [7:0]     win [25];

    logic           pv [CONV_LAT];
    logic [9:0]     px [CONV_LAT];
    logic [8:0]     py [CONV_LAT];

    assign lb_rd = lb_mem[pos_x[AW-1:0]];

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        sof_restart = 1'b0;
        pos_x       = x_cnt;
        pos_y       = y_cnt;
        case (state)
            IDLE: begin
                if (in_valid && in_sof) begin
                    accept    = 1'b1;
                    pos_x     = '0;
                    pos_y     = '0;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_sof) begin
                        sof_restart = 1'b1;
                        pos_x       = '0;
                        pos_y       = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DW'(CONV_LAT))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        last_pix = accept && (pos_x == 10'(IMG_W - 1)) && (pos_y == 9'(IMG_H - 1));
        if (last_pix)
            state_nxt = DRAIN;

        win_ok = accept && (pos_x >= 10'd4) && (pos_y >= 9'd4);

        if (pos_x == 10'(IMG_W - 1)) begin
            x_nxt = '0;
            y_nxt = pos_y + 9'd1;
        end else begin
            x_nxt = pos_x + 10'd1;
            y_nxt = pos_y;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            lb_mem[pos_x[AW-1:0]] <= {in_pixel, lb_rd[31:8]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            drain_cnt  <= '0;
            conv_en    <= 1'b0;
            sof_err    <= 1'b0;
            frame_done <= 1'b0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            for (int unsigned k = 0; k < 25; k++)
                win[k] <= '0;
            for (int unsigned i = 0; i < CONV_LAT; i++) begin
                pv[i] <= 1'b0;
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            conv_en    <= win_ok;
            sof_err    <= sof_restart;
            frame_done <= (state == DRAIN) && (drain_cnt == DW'(CONV_LAT));
            drain_cnt  <= (state == DRAIN) ? DW'(drain_cnt + 1'b1) : '0;

            if (accept) begin
                x_cnt <= x_nxt;
                y_cnt <= y_nxt;
                // Shift toward c=0; new column is line-buffer rows plus the live pixel.
                for (int unsigned r = 0; r < 5; r++) begin
                    for (int unsigned c = 0; c < 4; c++)
                        win[r*5+c] <= win[r*5+c+1];
                end
                for (int unsigned r = 0; r < 4; r++)
                    win[r*5+4] <= lb_rd[r*8 +: 8];
                win[24] <= in_pixel;
            end

            pv[0] <= win_ok;
            px[0] <= pos_x - 10'd2;
            py[0] <= pos_y - 9'd2;
            for (int unsigned i = 1; i < CONV_LAT; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end

            out_valid <= pv[CONV_LAT-1];
            if (pv[CONV_LAT-1]) begin
                out_x <= px[CONV_LAT-1];
                out_y <= py[CONV_LAT-1];
            end
        end
    end

    always_comb begin
        window_data = '0;
        for (int unsigned k = 0; k < 25; k++)
            window_data[k*8 +: 8] = win[k];
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl on an 8x6 frame with a 3-cycle
// Gaussian convolution model attached to the window outputs.
module tb_conv_window_ctrl;

    localparam int W = 8;
    localparam int H = 6;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_sof;
    logic [7:0]   in_pixel;
    logic [199:0] window_data;
    logic         conv_en;
    logic         out_valid;
    logic [9:0]   out_x;
    logic [8:0]   out_y;
    logic         frame_done;
    logic         sof_err;

    always #5 clk = ~clk;

    conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .CONV_LAT(L)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .window_data(window_data), .conv_en(conv_en),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference 5x5 Gaussian (1-4-6-4-1 outer product, /256), 3-cycle pipeline.
    function automatic logic [7:0] gauss(input logic [199:0] w);
        int s;
        int wt [5];
        wt = '{1, 4, 6, 4, 1};
        s = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                s += wt[r] * wt[c] * int'(w[(r*5+c)*8 +: 8]);
        return 8'(s >> 8);
    endfunction

    logic [7:0] cd [3];
    logic       cv [3];
    always @(posedge clk) begin
        cv[0] <= conv_en;
        cd[0] <= gauss(window_data);
        cv[1] <= cv[0];
        cd[1] <= cd[0];
        cv[2] <= cv[1];
        cd[2] <= cd[1];
    end

    typedef struct {
        int         cx;
        int         cy;
        logic [7:0] k0;
        logic [7:0] k4;
        logic [7:0] k20;
        logic [7:0] k24;
    } res_t;
    res_t tbl [8];

    int           conv_cyc [64];
    logic [199:0] conv_win [64];
    int           out_cyc [64];
    int           ox [64];
    int           oy [64];
    int           qual_cyc [64];
    int           exp_idx [64];
    int           n_conv, n_out, n_fd, n_err, n_qual, n_exp;
    int           fd_cyc, err_cyc;
    bit           chk_conv_data = 1'b0;

    always @(negedge clk) begin
        if (conv_en && n_conv < 64) begin
            conv_cyc[n_conv] = cyc;
            conv_win[n_conv] = window_data;
            n_conv++;
        end
        if (out_valid && n_out < 64) begin
            out_cyc[n_out] = cyc;
            ox[n_out] = int'(out_x);
            oy[n_out] = int'(out_y);
            n_out++;
            if (chk_conv_data) begin
                chk("conv_valid_at_out", longint'(cv[2]), 1);
                chk("conv_data_at_out", longint'(cd[2]), 100);
            end
        end
        if (frame_done) begin
            fd_cyc = cyc;
            n_fd++;
        end
        if (sof_err) begin
            err_cyc = cyc;
            n_err++;
        end
    end

    task automatic clear_mon();
        n_conv = 0; n_out = 0; n_fd = 0; n_err = 0; n_qual = 0; n_exp = 0;
        fd_cyc = -1; err_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input int x, input int y, input bit sof, input bit gap,
                            input logic [7:0] pix);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix;
        if (x >= 4 && y >= 4 && n_qual < 64) begin
            qual_cyc[n_qual] = cyc;
            n_qual++;
        end
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (gap) tick();
    endtask

    task automatic send_frame(input bit gap, input int stop_at, input bit constant);
        for (int idx = 0; idx < W*H; idx++) begin
            if (idx == stop_at) return;
            send_pix(idx % W, idx / W, idx == 0, gap,
                     constant ? 8'd100 : 8'((idx % W) + 16 * (idx / W)));
        end
    endtask

    task automatic expect_full();
        for (int i = 0; i < 8; i++) begin
            exp_idx[n_exp] = i;
            n_exp++;
        end
    endtask

    task automatic check_results(input int exp_fd);
        logic [199:0] ew;
        res_t e;
        chk("conv_en_count", n_conv, n_exp);
        chk("out_valid_count", n_out, n_exp);
        chk("frame_done_count", n_fd, exp_fd);
        for (int i = 0; i < n_exp && i < n_conv && i < n_out; i++) begin
            e = tbl[exp_idx[i]];
            chk("win_k0", longint'(conv_win[i][0*8 +: 8]), longint'(e.k0));
            chk("win_k4", longint'(conv_win[i][4*8 +: 8]), longint'(e.k4));
            chk("win_k20", longint'(conv_win[i][20*8 +: 8]), longint'(e.k20));
            chk("win_k24", longint'(conv_win[i][24*8 +: 8]), longint'(e.k24));
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    ew[(r*5+c)*8 +: 8] = 8'((e.cx - 2 + c) + 16 * (e.cy - 2 + r));
            chk_w("win_full", conv_win[i], ew);
            chk("out_x", ox[i], e.cx);
            chk("out_y", oy[i], e.cy);
            chk("conv_en_timing", conv_cyc[i], qual_cyc[i] + 1);
            chk("out_latency", out_cyc[i], conv_cyc[i] + L);
        end
        if (exp_fd > 0 && n_out > 0)
            chk("frame_done_timing", fd_cyc, out_cyc[n_out-1] + 1);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        int sof_cyc;
        tbl[0] = '{2, 2, 8'h00, 8'h04, 8'h40, 8'h44};
        tbl[1] = '{3, 2, 8'h01, 8'h05, 8'h41, 8'h45};
        tbl[2] = '{4, 2, 8'h02, 8'h06, 8'h42, 8'h46};
        tbl[3] = '{5, 2, 8'h03, 8'h07, 8'h43, 8'h47};
        tbl[4] = '{2, 3, 8'h10, 8'h14, 8'h50, 8'h54};
        tbl[5] = '{3, 3, 8'h11, 8'h15, 8'h51, 8'h55};
        tbl[6] = '{4, 3, 8'h12, 8'h16, 8'h52, 8'h56};
        tbl[7] = '{5, 3, 8'h13, 8'h17, 8'h53, 8'h57};

        clear_mon();
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        repeat (3) tick();
        chk_w("rst_window_data", window_data, '0);
        chk("rst_conv_en", longint'(conv_en), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_x", longint'(out_x), 0);
        chk("rst_out_y", longint'(out_y), 0);
        chk("rst_frame_done", longint'(frame_done), 0);
        chk("rst_sof_err", longint'(sof_err), 0);
        reset = 1'b0;
        tick();

        // Continuous ramp frame
        clear_mon(); expect_full();
        send_frame(1'b0, -1, 1'b0);
        repeat (10) tick();
        check_results(1);

        // Same frame with 1-0-1-0 valid pattern
        clear_mon(); expect_full();
        send_frame(1'b1, -1, 1'b0);
        repeat (10) tick();
        check_results(1);

        // Pixels without sof in IDLE are dropped
        clear_mon();
        for (int i = 0; i < 10; i++) send_pix(0, 0, 1'b0, 1'b0, 8'(i));
        repeat (6) tick();
        chk("idle_conv_en", n_conv, 0);
        chk("idle_out_valid", n_out, 0);
        chk("idle_sof_err", n_err, 0);
        chk("idle_frame_done", n_fd, 0);
        clear_mon(); expect_full();
        send_frame(1'b0, -1, 1'b0);
        repeat (10) tick();
        check_results(1);

        // Restart at pixel (3,5): old row-4 results plus a full new frame
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            exp_idx[n_exp] = i;
            n_exp++;
        end
        expect_full();
        send_frame(1'b0, 5*W + 3, 1'b0);
        sof_cyc = cyc;
        send_frame(1'b0, -1, 1'b0);
        repeat (10) tick();
        chk("sof_err_count", n_err, 1);
        chk("sof_err_timing", err_cyc, sof_cyc + 1);
        check_results(1);

        // Reset mid-row with results in flight
        clear_mon();
        send_frame(1'b0, 4*W + 6, 1'b0);
        reset = 1'b1;
        tick();
        chk_w("midrst_window_data", window_data, '0);
        chk("midrst_conv_en", longint'(conv_en), 0);
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_out_x", longint'(out_x), 0);
        chk("midrst_out_y", longint'(out_y), 0);
        reset = 1'b0;
        n_out = 0; n_fd = 0;
        repeat (10) tick();
        chk("midrst_no_pending_out", n_out, 0);
        chk("midrst_no_frame_done", n_fd, 0);
        clear_mon(); expect_full();
        send_frame(1'b0, -1, 1'b0);
        repeat (10) tick();
        check_results(1);

        // Constant frame through the convolution model
        clear_mon();
        chk_conv_data = 1'b1;
        send_frame(1'b0, -1, 1'b1);
        repeat (10) tick();
        chk_conv_data = 1'b0;
        chk("const_out_count", n_out, 8);
        chk("const_frame_done", n_fd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
